// File: rtl/rv32i_types_pkg.sv
// rv32i_types: shared memory-interface constants used by the burst responder.
package rv32i_types;
    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;
    typedef logic [1:0] beat_t;
endpackage

// File: rtl/burst_mem_array.sv
// burst_mem_array: line storage with a synchronous 256-bit write port and a combinational read port.
module burst_mem_array
    import rv32i_types::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_BITS-1:0] widx,
    input  logic [LINE_W-1:0]   wline,
    input  logic [IDX_BITS-1:0] ridx,
    output logic [LINE_W-1:0]   rline
);
    logic [LINE_W-1:0] mem [2**IDX_BITS];
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wline;
    end
    assign rline = mem[ridx];
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: fixed-latency 4-beat line read/write responder over a small aliased memory.
module burst_mem_responder
    import rv32i_types::*;
#(
    parameter int IDX_BITS = 4,
    parameter int LATENCY  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp
);
    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
    localparam logic [3:0] LAT_LAST  = 4'(LATENCY - 1);
    localparam beat_t      BEAT_LAST = beat_t'(BEATS - 1);
    state_t state, state_n;
    logic op_wr, req_held, we, unused_addr;
    logic [IDX_BITS-1:0] idx;
    logic [3:0] lat_cnt;
    beat_t beat;
    logic [BEATS-1:0][BEAT_W-1:0] wbuf, line_wr, line_rd;
    assign req_held    = op_wr ? pmem_write : pmem_read;
    assign unused_addr = ^{pmem_address[31:IDX_BITS+OFFSET_BITS], pmem_address[OFFSET_BITS-1:0]};
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = (pmem_read || pmem_write) ? WAIT : IDLE;
            WAIT:    state_n = !req_held ? IDLE : (lat_cnt == LAT_LAST) ? BURST : WAIT;
            BURST:   state_n = (beat == BEAT_LAST) ? DONE : BURST;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
            beat    <= '0;
        end else begin
            state   <= state_n;
            lat_cnt <= (state == WAIT) ? lat_cnt + 4'd1 : '0;
            beat    <= (state == BURST) ? beat + beat_t'(1) : '0;
            if (state == IDLE) begin
                op_wr <= pmem_write && !pmem_read;
                idx   <= pmem_address[IDX_BITS+OFFSET_BITS-1:OFFSET_BITS];
            end
            if (state == BURST && op_wr) wbuf[beat] <= pmem_wdata;
        end
    end
    // last beat bypasses the buffer so the whole line lands in one edge
    always_comb begin
        line_wr = wbuf;
        line_wr[BEATS-1] = pmem_wdata;
    end
    assign we         = reset_n && state == BURST && op_wr && beat == BEAT_LAST;
    assign pmem_resp  = (state == BURST);
    assign pmem_rdata = pmem_resp ? line_rd[beat] : '0;
    burst_mem_array #(.IDX_BITS(IDX_BITS)) u_array (
        .clk   (clk),
        .we    (we),
        .widx  (idx),
        .wline (line_wr),
        .ridx  (idx),
        .rline (line_rd)
    );
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: scoreboard bench for burst_mem_responder at default parameters.
module tb_burst_mem_responder;
    localparam int LAT = 3;
    typedef struct {logic [63:0] data; bit care;} exp_t;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        pmem_read = 0;
    logic        pmem_write = 0;
    logic [31:0] pmem_address = '0;
    logic [63:0] pmem_wdata = '0;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;
    exp_t        sb[$];
    logic [255:0] model [16];
    int  n_vec = 0;
    int  n_bad = 0;
    bit  mon_en = 0;
    logic [255:0] l1, l2, l3, l4, l5, l6;
    burst_mem_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (mon_en) begin
            if (pmem_resp) begin
                if (sb.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.care) check("rdata_beat", pmem_rdata, e.data);
                end
            end else check("rdata_idle", pmem_rdata, 64'd0);
        end
    end
    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wl, input int drop_at);
        int idx, k, w;
        exp_t e;
        idx = int'(addr[8:5]);
        for (int b = 0; b < 4; b++) begin
            e.data = rd ? model[idx][b*64 +: 64] : 64'd0;
            e.care = rd;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = '0;
        @(posedge clk); #1;
        pmem_address = ~addr;
        k = 0;
        do begin @(negedge clk); k++; end while (!pmem_resp && k < 20);
        check("first_resp_latency", 64'(k), 64'(LAT + 1));
        w = 0;
        while (pmem_resp && w < 8) begin
            pmem_wdata = wl[w*64 +: 64];
            if (w == drop_at) begin pmem_read = 0; pmem_write = 0; end
            w++;
            @(negedge clk);
        end
        pmem_read = 0; pmem_write = 0;
        check("resp_width", 64'(w), 64'd4);
        check("resp_low_after", 64'(pmem_resp), 64'd0);
        if (wr && !rd) model[idx] = wl;
    endtask
    initial begin
        int seen, w;
        exp_t e;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
    initial begin
        int seen, w;
        exp_t e;
        l1 = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        l2 = rand_line(); l3 = rand_line(); l4 = rand_line(); l5 = rand_line(); l6 = rand_line();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_resp", 64'(pmem_resp), 64'd0);
        check("reset_rdata", pmem_rdata, 64'd0);
        mon_en = 1;
        @(posedge clk); #1 reset_n = 1;
        xfer(0, 1, 32'h0000_0040, l1, 3);
        xfer(1, 0, 32'h0000_0040, '0, 3);
        xfer(0, 1, 32'h0000_0040, l2, 3);
        xfer(1, 0, 32'h0000_0040, '0, 3);
        @(posedge clk); #1;
        pmem_write = 1; pmem_address = 32'h0000_0040; pmem_wdata = 64'hdead;
        @(posedge clk); @(posedge clk); #1 pmem_write = 0;
        seen = 0;
        repeat (10) begin @(negedge clk); seen += int'(pmem_resp); end
        check("wait_drop_no_resp", 64'(seen), 64'd0);
        xfer(1, 0, 32'h0000_0040, '0, 3);
        xfer(0, 1, 32'h0000_0060, l3, 3);
        for (int b = 0; b < 4; b++) begin e.data = '0; e.care = 0; sb.push_back(e); end
        @(posedge clk); #1;
        pmem_write = 1; pmem_address = 32'h0000_0060;
        w = 0;
        while (w < 40 && !(pmem_resp && w == 2)) begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_wdata = l4[w*64 +: 64];
                if (w < 2) w++;
            end else if (w == 0) seen++;
        end
        reset_n = 0; pmem_write = 0;
        @(negedge clk);
        check("reset_mid_burst_resp", 64'(pmem_resp), 64'd0);
        check("reset_mid_burst_rdata", pmem_rdata, 64'd0);
        @(posedge clk); #1 reset_n = 1;
        sb.delete();
        seen = 0;
        repeat (6) begin @(negedge clk); seen += int'(pmem_resp); end
        check("idle_after_reset", 64'(seen), 64'd0);
        xfer(1, 0, 32'h0000_0060, '0, 3);
        xfer(0, 1, 32'h0000_0020, l5, 3);
        xfer(1, 0, 32'h0000_0220, '0, 3);
        xfer(1, 0, 32'h0000_003C, '0, 3);
        xfer(1, 1, 32'h0000_0020, l6, 3);
        xfer(1, 0, 32'h0000_0020, '0, 3);
        xfer(0, 1, 32'h0000_0180, l6, 1);
        xfer(1, 0, 32'h0000_0180, '0, 3);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
